// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper.
// Provides the FSM state encoding and the default sweep size. The bench
// imports the same package, so it sees the same state values and vector count.
package truth_table_sweeper_pkg;

  // Default number of swept inputs and the resulting number of vectors
  localparam int N_IN_DEFAULT = 4;
  localparam int N_VEC        = 2 ** N_IN_DEFAULT;

  // State encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    RUN  = S_RUN,
    DONE = S_DONE
  } state_t;

endpackage

// File: rtl/truth_table_sweeper_hold_timer.sv
// hold_timer: modulo-HOLD cycle counter used to pace the sweep.
// Ports:
//   iClk    clock, rising edge
//   iRst_n  asynchronous active-low reset
//   iClear  synchronous clear; the count is held at 0 while it is high
//   oTc     terminal count, high while the count equals HOLD-1
// The count advances on every edge where iClear is low and wraps to 0 after
// the terminal count. With HOLD=1 the count stays at 0 and oTc is always high.
module hold_timer #(
  parameter int HOLD = 10
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iClear,
  output logic oTc
);

  localparam int            W      = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [W-1:0]  TC_VAL = W'(HOLD - 1);

  logic [W-1:0] count;

  assign oTc = (count == TC_VAL);

  // Free-running modulo counter, parked at zero while cleared
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      count <= '0;
    end else if (iClear) begin
      count <= '0;
    end else if (oTc) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives every input combination of a combinational
// block, holds each one for HOLD cycles, captures the block's response into a
// truth table and compares it with the EXPECTED constant.
// Ports:
//   iClk    clock, rising edge
//   iRst_n  asynchronous active-low reset
//   iStart  start or restart a sweep (level-sampled)
//   iAbort  abandon the sweep; wins over iStart
//   iY      response of the block under test
//   oVec    vector driven to the block (MSB is input A)
//   oIdx    index of the vector being driven
//   oBusy   sweep in progress
//   oDone   sweep finished, oTable valid
//   oTable  captured truth table, bit k is the response to vector k
//   oPass   oDone and oTable matches EXPECTED
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int          N_IN     = N_IN_DEFAULT,
  parameter int          HOLD     = 10,
  parameter logic [15:0] EXPECTED = 16'h0000
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic                 iStart,
  input  logic                 iAbort,
  input  logic                 iY,
  output logic [N_IN-1:0]      oVec,
  output logic [N_IN-1:0]      oIdx,
  output logic                 oBusy,
  output logic                 oDone,
  output logic [2**N_IN-1:0]   oTable,
  output logic                 oPass
);

  localparam int              NV       = 2 ** N_IN;
  localparam logic [N_IN-1:0] IDX_LAST = N_IN'(NV - 1);

  state_t          state;
  logic [N_IN-1:0] idx;
  logic            tc;
  logic [NV-1:0]   table_next;

  // The timer only runs during a sweep, so every sweep starts from count 0
  hold_timer #(.HOLD(HOLD)) u_hold_timer (
    .iClk   (iClk),
    .iRst_n (iRst_n),
    .iClear (state != RUN),
    .oTc    (tc)
  );

  // Table as it will look after the current sample lands; oPass is computed
  // from this so it is valid on the same edge that raises oDone
  always_comb begin
    table_next      = oTable;
    table_next[idx] = iY;
  end

  // Sweep controller. The end of the sweep is decided from the index before
  // it wraps back to zero.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state  <= IDLE;
      idx    <= '0;
      oVec   <= '0;
      oIdx   <= '0;
      oBusy  <= 1'b0;
      oDone  <= 1'b0;
      oTable <= '0;
      oPass  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iStart && !iAbort) begin
            state  <= RUN;
            idx    <= '0;
            oVec   <= '0;
            oIdx   <= '0;
            oTable <= '0;
            oBusy  <= 1'b1;
          end
        end

        RUN: begin
          if (iAbort) begin
            state <= IDLE;
            idx   <= '0;
            oVec  <= '0;
            oIdx  <= '0;
            oBusy <= 1'b0;
            oDone <= 1'b0;
          end else if (tc) begin
            oTable <= table_next;
            idx    <= idx + 1'b1;
            if (idx == IDX_LAST) begin
              state <= DONE;
              oVec  <= '0;
              oIdx  <= '0;
              oBusy <= 1'b0;
              oDone <= 1'b1;
              oPass <= (table_next == EXPECTED[NV-1:0]);
            end else begin
              oVec <= idx + 1'b1;
              oIdx <= idx + 1'b1;
            end
          end
        end

        DONE: begin
          if (iAbort) begin
            state <= IDLE;
            oDone <= 1'b0;
            oPass <= 1'b0;
          end else if (iStart) begin
            state  <= RUN;
            idx    <= '0;
            oVec   <= '0;
            oIdx   <= '0;
            oTable <= '0;
            oBusy  <= 1'b1;
            oDone  <= 1'b0;
            oPass  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          idx   <= '0;
          oVec  <= '0;
          oIdx  <= '0;
          oBusy <= 1'b0;
          oDone <= 1'b0;
          oPass <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper.
// Two instances share clock and reset: dut_a (HOLD=10, EXPECTED=16'hF000)
// and dut_b (HOLD=1, EXPECTED=16'hAAAA). Each one's iY is produced by a
// selectable function of its own oVec; the reference table is built by
// evaluating that same function over all vectors.
module tb_truth_table_sweeper;
  import truth_table_sweeper_pkg::*;

  localparam int HOLD_A = 10;
  localparam int HOLD_B = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic start_a = 1'b0, abort_a = 1'b0, y_a;
  logic start_b = 1'b0, abort_b = 1'b0, y_b;
  logic [3:0]  vec_a, idx_a, vec_b, idx_b;
  logic [15:0] tbl_a, tbl_b;
  logic busy_a, done_a, pass_a, busy_b, done_b, pass_b;

  int          mode_a = 0, mode_b = 0;
  logic [15:0] tt_a = 16'h0, tt_b = 16'h0;

  int n_cmp  = 0;
  int n_fail = 0;

  // Block under test: 0 = A&B, 1 = D, 2 = constant 1, otherwise random table
  function automatic logic dut_fn(int mode, logic [3:0] v, logic [15:0] tt);
    case (mode)
      0:       return v[3] & v[2];
      1:       return v[0];
      2:       return 1'b1;
      default: return tt[v];
    endcase
  endfunction

  // Expected truth table: the block evaluated on every vector
  function automatic logic [15:0] model_table(int mode, logic [15:0] tt);
    logic [15:0] t;
    t = '0;
    for (int k = 0; k < N_VEC; k++) t[k] = dut_fn(mode, 4'(k), tt);
    return t;
  endfunction

  assign y_a = dut_fn(mode_a, vec_a, tt_a);
  assign y_b = dut_fn(mode_b, vec_b, tt_b);

  always #5 clk = ~clk;

  truth_table_sweeper #(.N_IN(4), .HOLD(HOLD_A), .EXPECTED(16'hF000)) dut_a (
    .iClk(clk), .iRst_n(rst_n), .iStart(start_a), .iAbort(abort_a), .iY(y_a),
    .oVec(vec_a), .oIdx(idx_a), .oBusy(busy_a), .oDone(done_a),
    .oTable(tbl_a), .oPass(pass_a)
  );

  truth_table_sweeper #(.N_IN(4), .HOLD(HOLD_B), .EXPECTED(16'hAAAA)) dut_b (
    .iClk(clk), .iRst_n(rst_n), .iStart(start_b), .iAbort(abort_b), .iY(y_b),
    .oVec(vec_b), .oIdx(idx_b), .oBusy(busy_b), .oDone(done_b),
    .oTable(tbl_b), .oPass(pass_b)
  );

  // Advance to 1 ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({vec_a, idx_a, busy_a, done_a, tbl_a, pass_a} !== 27'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_a: got vec=%h idx=%h busy=%b done=%b tbl=%h pass=%b, want all 0",
               vec_a, idx_a, busy_a, done_a, tbl_a, pass_a);
    end
    n_cmp++;
    if ({vec_b, idx_b, busy_b, done_b, tbl_b, pass_b} !== 27'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_b: got vec=%h idx=%h busy=%b done=%b tbl=%h pass=%b, want all 0",
               vec_b, idx_b, busy_b, done_b, tbl_b, pass_b);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // A&B on dut_a: HOLD=10 pacing, done exactly 160 cycles after the start edge
  task automatic test_and_sweep();
    int cycles;
    logic [15:0] exp_t;
    mode_a = 0;
    exp_t  = model_table(mode_a, tt_a);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    cycles = 0;
    n_cmp++;
    if (busy_a !== 1'b1 || vec_a !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL and_start: got busy=%b vec=%h, want busy=1 vec=0", busy_a, vec_a);
    end
    while (done_a !== 1'b1 && cycles < 400) begin
      tick();
      cycles++;
      if (done_a !== 1'b1 && vec_a !== 4'(cycles / HOLD_A)) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL and_vec: cycle %0d got vec=%h, want %h", cycles, vec_a, 4'(cycles / HOLD_A));
      end
    end
    n_cmp++;
    if (cycles !== N_VEC * HOLD_A) begin
      n_fail++;
      $display("[TB] FAIL and_latency: got %0d cycles, want %0d", cycles, N_VEC * HOLD_A);
    end
    n_cmp++;
    if (tbl_a !== exp_t || pass_a !== 1'b1 || busy_a !== 1'b0 || vec_a !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL and_result: got tbl=%h pass=%b busy=%b vec=%h, want tbl=%h pass=1 busy=0 vec=0",
               tbl_a, pass_a, busy_a, vec_a, exp_t);
    end
  endtask

  // D on dut_b with HOLD=1: one vector per cycle
  task automatic test_d_sweep();
    int cycles;
    logic [15:0] exp_t;
    mode_b = 1;
    exp_t  = model_table(mode_b, tt_b);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    cycles = 0;
    while (done_b !== 1'b1 && cycles < 100) begin
      n_cmp++;
      if (vec_b !== 4'(cycles) || idx_b !== 4'(cycles)) begin
        n_fail++;
        $display("[TB] FAIL d_vec: cycle %0d got vec=%h idx=%h, want %h", cycles, vec_b, idx_b, 4'(cycles));
      end
      tick();
      cycles++;
    end
    n_cmp++;
    if (cycles !== N_VEC) begin
      n_fail++;
      $display("[TB] FAIL d_latency: got %0d cycles, want %0d", cycles, N_VEC);
    end
    n_cmp++;
    if (tbl_b !== exp_t || pass_b !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL d_result: got tbl=%h pass=%b, want tbl=%h pass=1", tbl_b, pass_b, exp_t);
    end
  endtask

  // Constant 1 on dut_b: table differs from EXPECTED so pass stays low
  task automatic test_const_one();
    int guard;
    mode_b = 2;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    guard = 0;
    while (done_b !== 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (done_b !== 1'b1 || tbl_b !== model_table(mode_b, tt_b) || pass_b !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL const_result: got done=%b tbl=%h pass=%b, want done=1 tbl=%h pass=0",
               done_b, tbl_b, pass_b, model_table(mode_b, tt_b));
    end
  endtask

  // Random table on dut_a, aborted at idx 5, then start+abort together
  task automatic test_abort();
    int guard;
    logic [15:0] exp_t;
    mode_a = 3;
    tt_a   = 16'($urandom);
    exp_t  = model_table(mode_a, tt_a) & 16'h001F;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    guard = 0;
    while (idx_a !== 4'd5 && guard < 200) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (idx_a !== 4'd5) begin
      n_fail++;
      $display("[TB] FAIL abort_wait: got idx=%h, want 5 within 200 cycles", idx_a);
    end
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    n_cmp++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || vec_a !== 4'd0 || tbl_a !== exp_t) begin
      n_fail++;
      $display("[TB] FAIL abort_state: got busy=%b done=%b vec=%h tbl=%h, want busy=0 done=0 vec=0 tbl=%h",
               busy_a, done_a, vec_a, tbl_a, exp_t);
    end
    start_a = 1'b1;
    abort_a = 1'b1;
    tick();
    tick();
    start_a = 1'b0;
    abort_a = 1'b0;
    n_cmp++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || tbl_a !== exp_t) begin
      n_fail++;
      $display("[TB] FAIL abort_wins: got busy=%b done=%b tbl=%h, want busy=0 done=0 tbl=%h",
               busy_a, done_a, tbl_a, exp_t);
    end
  endtask

  // Reset dropped between edges at idx 9, then a full fresh sweep
  task automatic test_reset_mid();
    int guard;
    int cycles;
    logic [15:0] exp_t;
    mode_a = 3;
    tt_a   = 16'($urandom);
    exp_t  = model_table(mode_a, tt_a);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    guard = 0;
    while (idx_a !== 4'd9 && guard < 200) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (idx_a !== 4'd9) begin
      n_fail++;
      $display("[TB] FAIL rstmid_wait: got idx=%h, want 9 within 200 cycles", idx_a);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({vec_a, idx_a, busy_a, done_a, tbl_a, pass_a} !== 27'd0) begin
      n_fail++;
      $display("[TB] FAIL rstmid_async: got vec=%h idx=%h busy=%b done=%b tbl=%h pass=%b, want all 0",
               vec_a, idx_a, busy_a, done_a, tbl_a, pass_a);
    end
    #2;
    rst_n = 1'b1;
    tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    cycles = 0;
    n_cmp++;
    if (idx_a !== 4'd0 || busy_a !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rstmid_restart: got idx=%h busy=%b, want idx=0 busy=1", idx_a, busy_a);
    end
    while (done_a !== 1'b1 && cycles < 400) begin
      tick();
      cycles++;
    end
    n_cmp++;
    if (cycles !== N_VEC * HOLD_A || tbl_a !== exp_t || pass_a !== (exp_t == 16'hF000)) begin
      n_fail++;
      $display("[TB] FAIL rstmid_sweep: got cycles=%0d tbl=%h pass=%b, want cycles=%0d tbl=%h pass=%b",
               cycles, tbl_a, pass_a, N_VEC * HOLD_A, exp_t, (exp_t == 16'hF000));
    end
  endtask

  // iStart held through a sweep on dut_b: no restart in RUN, restart after DONE
  task automatic test_start_held();
    int cycles;
    logic [15:0] exp_t;
    mode_b = 3;
    tt_b   = 16'($urandom);
    exp_t  = model_table(mode_b, tt_b);
    start_b = 1'b1;
    tick();
    cycles = 0;
    while (done_b !== 1'b1 && cycles < 100) begin
      n_cmp++;
      if (vec_b !== 4'(cycles)) begin
        n_fail++;
        $display("[TB] FAIL held_vec: cycle %0d got vec=%h, want %h", cycles, vec_b, 4'(cycles));
      end
      tick();
      cycles++;
    end
    n_cmp++;
    if (cycles !== N_VEC || tbl_b !== exp_t || pass_b !== (exp_t == 16'hAAAA)) begin
      n_fail++;
      $display("[TB] FAIL held_done: got cycles=%0d tbl=%h pass=%b, want cycles=%0d tbl=%h pass=%b",
               cycles, tbl_b, pass_b, N_VEC, exp_t, (exp_t == 16'hAAAA));
    end
    tick();
    start_b = 1'b0;
    n_cmp++;
    if (done_b !== 1'b0 || tbl_b !== 16'h0 || idx_b !== 4'd0 || busy_b !== 1'b1 || pass_b !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL held_restart: got done=%b tbl=%h idx=%h busy=%b pass=%b, want done=0 tbl=0 idx=0 busy=1 pass=0",
               done_b, tbl_b, idx_b, busy_b, pass_b);
    end
    abort_b = 1'b1;
    tick();
    abort_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_and_sweep();
    test_d_sweep();
    test_const_one();
    test_abort();
    test_reset_mid();
    test_start_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
